decoder_7_seg: RTL and testbench

Triple BCD-to-seven-segment decoder for the timer display path. It converts three 4-bit BCD digits (minutes, tens-of-seconds, seconds) into three 7-bit segment patterns. Outputs are registered and drive the display pins directly, downstream of the timer counter.

---
 rtl/decoder_7_seg_pkg.sv | 25 ++
 rtl/decoder_7_seg_bcd_to_7seg.sv | 37 +++
 rtl/decoder_7_seg.sv | 64 ++++++
 tb/tb_decoder_7_seg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_7_seg_pkg.sv
// Shared segment definitions for the timer display decoders.
// Bit order of every pattern: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
package decoder_7_seg_pkg;

    typedef logic [6:0] seg_t;

    // Active-high patterns (1 lights the segment)
    localparam seg_t SEG_0 = 7'h7E;
    localparam seg_t SEG_1 = 7'h30;
    localparam seg_t SEG_2 = 7'h6D;
    localparam seg_t SEG_3 = 7'h79;
    localparam seg_t SEG_4 = 7'h33;
    localparam seg_t SEG_5 = 7'h5B;
    localparam seg_t SEG_6 = 7'h5F;
    localparam seg_t SEG_7 = 7'h70;
    localparam seg_t SEG_8 = 7'h7F;
    localparam seg_t SEG_9 = 7'h7B;

    // Non-BCD codes show a lone middle bar
    localparam seg_t SEG_DASH = 7'h01;

    // Pattern loaded on reset: the digit zero
    localparam seg_t SEG_ZERO = SEG_0;

endpackage

// File: rtl/decoder_7_seg_bcd_to_7seg.sv
// Combinational decode of one BCD digit to a seven-segment pattern.
// ACTIVE_LOW selects common-anode polarity by inverting every segment.
module bcd_to_7seg
    import decoder_7_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] bcd,
    output seg_t       seg
);

    seg_t seg_hi;

    // Digit lookup in active-high form; codes 10-15 fall through to the dash
    always_comb begin
        seg_hi = SEG_DASH;
        case (bcd)
            4'd0:    seg_hi = SEG_0;
            4'd1:    seg_hi = SEG_1;
            4'd2:    seg_hi = SEG_2;
            4'd3:    seg_hi = SEG_3;
            4'd4:    seg_hi = SEG_4;
            4'd5:    seg_hi = SEG_5;
            4'd6:    seg_hi = SEG_6;
            4'd7:    seg_hi = SEG_7;
            4'd8:    seg_hi = SEG_8;
            4'd9:    seg_hi = SEG_9;
            default: seg_hi = SEG_DASH;
        endcase
    end

    // Apply display polarity
    always_comb begin
        seg = seg_hi ^ {7{ACTIVE_LOW}};
    end

endmodule

// File: rtl/decoder_7_seg.sv
// Triple BCD-to-seven-segment decoder for the timer display.
// Each digit decodes independently; outputs are registered (one cycle
// latency) so the display pins never see a combinational input path.
module decoder_7_seg
    import decoder_7_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min,
    input  logic [3:0] dSec,
    input  logic [3:0] sec,
    output logic [6:0] minOut,
    output logic [6:0] dsecOut,
    output logic [6:0] secOut
);

    // Reset shows "0" in whichever polarity the display uses
    localparam seg_t RST_PAT = SEG_ZERO ^ {7{ACTIVE_LOW}};

    seg_t min_seg_d;
    seg_t dsec_seg_d;
    seg_t sec_seg_d;
    seg_t min_seg_q;
    seg_t dsec_seg_q;
    seg_t sec_seg_q;

    bcd_to_7seg #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_min (
        .bcd (min),
        .seg (min_seg_d)
    );

    bcd_to_7seg #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_dsec (
        .bcd (dSec),
        .seg (dsec_seg_d)
    );

    bcd_to_7seg #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec_sec (
        .bcd (sec),
        .seg (sec_seg_d)
    );

    // Output registers; synchronous reset takes priority over new digits
    always_ff @(posedge clk) begin
        if (reset) begin
            min_seg_q  <= RST_PAT;
            dsec_seg_q <= RST_PAT;
            sec_seg_q  <= RST_PAT;
        end else begin
            min_seg_q  <= min_seg_d;
            dsec_seg_q <= dsec_seg_d;
            sec_seg_q  <= sec_seg_d;
        end
    end

    // Registered patterns drive the pins directly
    always_comb begin
        minOut  = min_seg_q;
        dsecOut = dsec_seg_q;
        secOut  = sec_seg_q;
    end

endmodule

// File: tb/tb_decoder_7_seg.sv
// Bench for decoder_7_seg: a common-cathode and a common-anode instance
// share clock, reset and digit inputs. Expected patterns come from a
// table of lit segment letters per digit.
module tb_decoder_7_seg;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] min_i, dsec_i, sec_i;
    logic [6:0] min_o, dsec_o, sec_o;
    logic [6:0] min_l, dsec_l, sec_l;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decoder_7_seg #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .reset(reset), .min(min_i), .dSec(dsec_i), .sec(sec_i),
        .minOut(min_o), .dsecOut(dsec_o), .secOut(sec_o)
    );

    decoder_7_seg #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .reset(reset), .min(min_i), .dSec(dsec_i), .sec(sec_i),
        .minOut(min_l), .dsecOut(dsec_l), .secOut(sec_l)
    );

    // Segments lit for each decimal digit, named by letter a..g
    string shapes [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                           "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] lit(input string s);
        logic [6:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - 97;
            r[6 - idx] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [6:0] model(input int v, input bit al);
        logic [6:0] r;
        if (v < 10) r = lit(shapes[v]);
        else        r = lit("g");
        return al ? ~r : r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; min_i = 4'h9; dsec_i = 4'h9; sec_i = 4'h9;
        for (int c = 0; c < 2; c++) begin
            step();
            tests_run++;
            if (min_o !== 7'h7E || dsec_o !== 7'h7E || sec_o !== 7'h7E) begin
                tests_failed++;
                $display("FAIL reset_hold cyc%0d: got %h %h %h want 7e", c, min_o, dsec_o, sec_o);
            end
            tests_run++;
            if (min_l !== 7'h01 || dsec_l !== 7'h01 || sec_l !== 7'h01) begin
                tests_failed++;
                $display("FAIL reset_hold_al cyc%0d: got %h %h %h want 01", c, min_l, dsec_l, sec_l);
            end
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (min_o !== 7'h7B || dsec_o !== 7'h7B || sec_o !== 7'h7B) begin
            tests_failed++;
            $display("FAIL reset_release: got %h %h %h want 7b", min_o, dsec_o, sec_o);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] want [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        for (int v = 0; v < 10; v++) begin
            min_i = 4'(v); dsec_i = 4'(v); sec_i = 4'(v);
            step();
            tests_run++;
            if (min_o !== want[v] || dsec_o !== want[v] || sec_o !== want[v] ||
                want[v] !== model(v, 1'b0)) begin
                tests_failed++;
                $display("FAIL sweep digit%0d: got %h %h %h want %h", v, min_o, dsec_o, sec_o, want[v]);
            end
        end
    endtask

    task automatic test_independence();
        min_i = 4'd1; dsec_i = 4'd5; sec_i = 4'd8;
        step();
        tests_run++;
        if (min_o !== 7'h30 || dsec_o !== 7'h5B || sec_o !== 7'h7F) begin
            tests_failed++;
            $display("FAIL independence: got %h %h %h want 30 5b 7f", min_o, dsec_o, sec_o);
        end
    endtask

    task automatic test_invalid();
        min_i = 4'd0; dsec_i = 4'd0;
        for (int v = 10; v < 16; v++) begin
            sec_i = 4'(v);
            step();
            tests_run++;
            if (sec_o !== 7'h01 || min_o !== 7'h7E || dsec_o !== 7'h7E) begin
                tests_failed++;
                $display("FAIL invalid code%0d: got sec=%h min=%h dsec=%h want 01 7e 7e", v, sec_o, min_o, dsec_o);
            end
            tests_run++;
            if (sec_l !== 7'h7E) begin
                tests_failed++;
                $display("FAIL invalid_al code%0d: got %h want 7e", v, sec_l);
            end
        end
    endtask

    task automatic test_latency();
        sec_i = 4'd3;
        step();
        tests_run++;
        if (sec_o !== 7'h79) begin
            tests_failed++;
            $display("FAIL latency_pre: got %h want 79", sec_o);
        end
        #2 sec_i = 4'd4;
        #1;
        tests_run++;
        if (sec_o !== 7'h79) begin
            tests_failed++;
            $display("FAIL latency_comb_path: got %h want 79", sec_o);
        end
        step();
        tests_run++;
        if (sec_o !== 7'h33) begin
            tests_failed++;
            $display("FAIL latency_post: got %h want 33", sec_o);
        end
    endtask

    task automatic test_active_low();
        sec_i = 4'd0;
        step();
        tests_run++;
        if (sec_l !== 7'h01) begin
            tests_failed++;
            $display("FAIL al_zero: got %h want 01", sec_l);
        end
        sec_i = 4'd8; reset = 1'b1;
        step();
        tests_run++;
        if (sec_l !== 7'h01) begin
            tests_failed++;
            $display("FAIL al_reset: got %h want 01", sec_l);
        end
        reset = 1'b0;
        step();
        tests_run++;
        if (sec_l !== 7'h00) begin
            tests_failed++;
            $display("FAIL al_eight: got %h want 00", sec_l);
        end
    endtask

    // Random digits with occasional single-cycle reset pulses, every cycle checked
    task automatic test_back_to_back();
        int m, d, s;
        bit r;
        logic [6:0] em, ed, es;
        for (int c = 0; c < 300; c++) begin
            m = $urandom_range(0, 15);
            d = $urandom_range(0, 15);
            s = $urandom_range(0, 15);
            r = ($urandom_range(0, 15) == 0);
            min_i = 4'(m); dsec_i = 4'(d); sec_i = 4'(s); reset = r;
            step();
            for (int al = 0; al < 2; al++) begin
                em = r ? model(0, al[0]) : model(m, al[0]);
                ed = r ? model(0, al[0]) : model(d, al[0]);
                es = r ? model(0, al[0]) : model(s, al[0]);
                tests_run++;
                if (al == 0 && (min_o !== em || dsec_o !== ed || sec_o !== es)) begin
                    tests_failed++;
                    $display("FAIL random cyc%0d in=%0d,%0d,%0d rst=%0d: got %h %h %h want %h %h %h",
                             c, m, d, s, r, min_o, dsec_o, sec_o, em, ed, es);
                end
                if (al == 1 && (min_l !== em || dsec_l !== ed || sec_l !== es)) begin
                    tests_failed++;
                    $display("FAIL random_al cyc%0d in=%0d,%0d,%0d rst=%0d: got %h %h %h want %h %h %h",
                             c, m, d, s, r, min_l, dsec_l, sec_l, em, ed, es);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; min_i = '0; dsec_i = '0; sec_i = '0;
        @(negedge clk);
        test_reset();
        test_sweep();
        test_independence();
        test_invalid();
        test_latency();
        test_active_low();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
